result_collector: RTL and testbench

//  Downstream sink for the W result of the 4-state program datapath (t1..t4 controller).
//  - Each t4 writeback produces one 8-bit W value; this block captures it into a FIFO
//    and drains it through a valid/ready output port.
//  - Keeps running statistics (count, saturating sum, min, max) and a sticky overflow flag.

---
 rtl/collector_pkg.sv | 13 +
 rtl/result_fifo_mem.sv | 27 ++
 rtl/result_collector.sv | 173 +++++++++++++++++
 tb/tb_result_collector.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/collector_pkg.sv
// Shared types and default widths for the W result collector.
package collector_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int SUM_W_DEF  = 16;

endpackage

// File: rtl/result_fifo_mem.sv
// Result FIFO storage: register array with a synchronous write port and a
// combinational (show-ahead) read port. Contents are never cleared.
module result_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write port: capture on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/result_collector.sv
// Sink for t4 W writebacks: buffers results in a FIFO drained over valid/ready
// and keeps running count/saturating-sum/min/max plus a sticky overflow flag.
module result_collector
  import collector_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 8,
  parameter int SUM_W  = SUM_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid,
  input  logic [DATA_W-1:0]          res_data,
  input  logic                       clr_stats,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       overflow,
  output logic [CNT_W-1:0]           n_seen,
  output logic [SUM_W-1:0]           sum,
  output logic [DATA_W-1:0]          min_v,
  output logic [DATA_W-1:0]          max_v
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  state_t            state_r, state_nx_s;
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic              push_s, pop_s, drop_s;

  logic              overflow_r, overflow_nx_s;
  logic [CNT_W-1:0]  n_seen_r, n_seen_nx_s, n_base_s;
  logic [SUM_W-1:0]  sum_r, sum_nx_s, sum_base_s;
  logic [DATA_W-1:0] min_r, min_nx_s, min_base_s;
  logic [DATA_W-1:0] max_r, max_nx_s, max_base_s;

  // Clamp at all-ones instead of wrapping; the extra carry bit flags the wrap.
  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [SUM_W:0] t;
    t = {1'b0, a} + (SUM_W+1)'(b);
    if (t[SUM_W]) begin
      return {SUM_W{1'b1}};
    end else begin
      return t[SUM_W-1:0];
    end
  endfunction

  assign pop_s  = out_valid & out_ready;
  assign push_s = res_valid & (~full | pop_s);
  assign drop_s = res_valid & ~push_s;

  result_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (res_data),
    .raddr (rd_ptr_r),
    .rdata (out_data)
  );

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_EMPTY;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Occupancy next-state.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_EMPTY: begin
        if (push_s) state_nx_s = S_PART;
        else        state_nx_s = S_EMPTY;
      end
      S_PART: begin
        if (push_s && !pop_s && level_r == LW'(DEPTH - 1))   state_nx_s = S_FULL;
        else if (pop_s && !push_s && level_r == LW'(1))      state_nx_s = S_EMPTY;
        else                                                 state_nx_s = S_PART;
      end
      S_FULL: begin
        if (pop_s && !push_s) state_nx_s = S_PART;
        else                  state_nx_s = S_FULL;
      end
      default: state_nx_s = S_EMPTY;
    endcase
  end

  // Occupancy-derived handshake outputs.
  always_comb begin
    out_valid = 1'b0;
    full      = 1'b0;
    case (state_r)
      S_EMPTY: begin out_valid = 1'b0; full = 1'b0; end
      S_PART:  begin out_valid = 1'b1; full = 1'b0; end
      S_FULL:  begin out_valid = 1'b1; full = 1'b1; end
      default: begin out_valid = 1'b0; full = 1'b0; end
    endcase
  end

  // Pointers and level; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      if (push_s && !pop_s)      level_r <= level_r + LW'(1);
      else if (pop_s && !push_s) level_r <= level_r - LW'(1);
    end
  end

  // Stats next values: a clear restarts from reset values, then a same-cycle push applies.
  always_comb begin
    n_base_s   = clr_stats ? {CNT_W{1'b0}}  : n_seen_r;
    sum_base_s = clr_stats ? {SUM_W{1'b0}}  : sum_r;
    min_base_s = clr_stats ? {DATA_W{1'b1}} : min_r;
    max_base_s = clr_stats ? {DATA_W{1'b0}} : max_r;
    if (push_s) begin
      n_seen_nx_s = n_base_s + CNT_W'(1);
      sum_nx_s    = sat_add(sum_base_s, res_data);
      min_nx_s    = (res_data < min_base_s) ? res_data : min_base_s;
      max_nx_s    = (res_data > max_base_s) ? res_data : max_base_s;
    end else begin
      n_seen_nx_s = n_base_s;
      sum_nx_s    = sum_base_s;
      min_nx_s    = min_base_s;
      max_nx_s    = max_base_s;
    end
    if (drop_s) begin
      overflow_nx_s = 1'b1;
    end else if (clr_stats) begin
      overflow_nx_s = 1'b0;
    end else begin
      overflow_nx_s = overflow_r;
    end
  end

  // Stats and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_seen_r   <= {CNT_W{1'b0}};
      sum_r      <= {SUM_W{1'b0}};
      min_r      <= {DATA_W{1'b1}};
      max_r      <= {DATA_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      n_seen_r   <= n_seen_nx_s;
      sum_r      <= sum_nx_s;
      min_r      <= min_nx_s;
      max_r      <= max_nx_s;
      overflow_r <= overflow_nx_s;
    end
  end

  assign level    = level_r;
  assign overflow = overflow_r;
  assign n_seen   = n_seen_r;
  assign sum      = sum_r;
  assign min_v    = min_r;
  assign max_v    = max_r;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: queue-based reference model checked
// every cycle, plus hand-computed checkpoints for the main scenarios.
module tb_result_collector;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst, res_valid, clr_stats, out_ready;
  logic [7:0] res_data;

  logic       ov_a, full_a, ovf_a, ov_b, full_b, ovf_b;
  logic [7:0] od_a, n_a, mn_a, mx_a, od_b, n_b, mn_b, mx_b;
  logic [3:0] lv_a, lv_b;
  logic [15:0] sum_a;
  logic [7:0]  sum_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] q[$];
  int  m_n, m_sum16, m_sum8, m_min, m_max;
  bit  m_ovf;
  bit  started = 1'b0;

  always #5 clk = ~clk;

  result_collector #(.DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
    .clr_stats(clr_stats), .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .level(lv_a), .full(full_a), .overflow(ovf_a),
    .n_seen(n_a), .sum(sum_a), .min_v(mn_a), .max_v(mx_a)
  );

  result_collector #(.DEPTH(DEPTH), .SUM_W(8)) dut_b (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
    .clr_stats(clr_stats), .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .level(lv_b), .full(full_b), .overflow(ovf_b),
    .n_seen(n_b), .sum(sum_b), .min_v(mn_b), .max_v(mx_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: FIFO as a queue, stats as plain integers.
  always @(posedge clk) begin
    bit pop, push;
    started = 1'b1;
    if (rst) begin
      q.delete();
      m_n = 0; m_sum16 = 0; m_sum8 = 0; m_min = 255; m_max = 0; m_ovf = 1'b0;
    end else begin
      pop  = (q.size() > 0) && out_ready;
      push = res_valid && ((q.size() < DEPTH) || pop);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(res_data);
      if (clr_stats) begin
        m_n = 0; m_sum16 = 0; m_sum8 = 0; m_min = 255; m_max = 0;
      end
      if (push) begin
        m_n     = (m_n + 1) % 256;
        m_sum16 = (m_sum16 + res_data > 65535) ? 65535 : m_sum16 + res_data;
        m_sum8  = (m_sum8 + res_data > 255) ? 255 : m_sum8 + res_data;
        if (res_data < m_min) m_min = res_data;
        if (res_data > m_max) m_max = res_data;
      end
      if (res_valid && !push) m_ovf = 1'b1;
      else if (clr_stats)     m_ovf = 1'b0;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("a_valid", ov_a, q.size() != 0);
      chk("b_valid", ov_b, q.size() != 0);
      if (q.size() != 0) begin
        chk("a_data", od_a, q[0]);
        chk("b_data", od_b, q[0]);
      end
      chk("a_level", lv_a, q.size());
      chk("b_level", lv_b, q.size());
      chk("a_full", full_a, q.size() == DEPTH);
      chk("b_full", full_b, q.size() == DEPTH);
      chk("a_ovf", ovf_a, m_ovf);
      chk("b_ovf", ovf_b, m_ovf);
      chk("a_n", n_a, m_n);
      chk("b_n", n_b, m_n);
      chk("a_sum", sum_a, m_sum16);
      chk("b_sum8", sum_b, m_sum8);
      chk("a_min", mn_a, m_min);
      chk("b_min", mn_b, m_min);
      chk("a_max", mx_a, m_max);
      chk("b_max", mx_b, m_max);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
    res_valid = v; res_data = d; out_ready = rdy; clr_stats = clr;
    @(posedge clk);
    #2;
  endtask

  int exp_drain[8] = '{2, 3, 4, 5, 6, 7, 8, 9};

  initial begin
    rst = 1'b1; res_valid = 1'b0; res_data = 8'd0; out_ready = 1'b0; clr_stats = 1'b0;
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    chk("rst_valid", ov_a, 0);
    chk("rst_level", lv_a, 0);
    chk("rst_min", mn_a, 8'hFF);
    chk("rst_max", mx_a, 0);
    chk("rst_sum", sum_a, 0);
    chk("rst_ovf", ovf_a, 0);
    rst = 1'b0;

    // Single push, not yet drained
    cyc(1'b1, 8'd5, 1'b0, 1'b0);
    chk("t2_valid", ov_a, 1);
    chk("t2_data", od_a, 5);
    chk("t2_level", lv_a, 1);
    chk("t2_n", n_a, 1);
    chk("t2_sum", sum_a, 5);
    chk("t2_min", mn_a, 5);
    chk("t2_max", mx_a, 5);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t2_drained", lv_a, 0);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    chk("clr_min", mn_a, 8'hFF);

    // Overfill: 1..10 into 8 entries
    for (int i = 1; i <= 10; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t3_level", lv_a, 8);
    chk("t3_full", full_a, 1);
    chk("t3_ovf", ovf_a, 1);
    chk("t3_n", n_a, 8);
    chk("t3_sum", sum_a, 36);
    chk("t3_head", od_a, 1);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    chk("clr_ovf", ovf_a, 0);
    chk("clr_keeps_fifo", lv_a, 8);

    // Full with simultaneous push and pop
    cyc(1'b1, 8'd9, 1'b1, 1'b0);
    chk("t4_level", lv_a, 8);
    chk("t4_ovf", ovf_a, 0);
    chk("t4_full", full_a, 1);
    for (int k = 0; k < 8; k++) begin
      chk("t4_drain", od_a, exp_drain[k]);
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
    end
    chk("t4_empty", ov_a, 0);

    // Sum saturation on the SUM_W=8 instance
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    cyc(1'b1, 8'd200, 1'b1, 1'b0);
    cyc(1'b1, 8'd200, 1'b1, 1'b0);
    chk("t5_sum8", sum_b, 8'hFF);
    chk("t5_sum16", sum_a, 400);
    chk("t5_level", lv_a, 1);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // Clear together with a push
    cyc(1'b1, 8'd3, 1'b0, 1'b0);
    cyc(1'b1, 8'd4, 1'b0, 1'b0);
    cyc(1'b1, 8'd7, 1'b0, 1'b1);
    chk("t6_n", n_a, 1);
    chk("t6_sum", sum_a, 7);
    chk("t6_min", mn_a, 7);
    chk("t6_max", mx_a, 7);
    chk("t6_level", lv_a, 3);
    chk("t6_head", od_a, 3);

    // Clear together with a dropped push: the drop wins
    for (int i = 10; i < 15; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'd99, 1'b0, 1'b1);
    chk("clrdrop_ovf", ovf_a, 1);
    chk("clrdrop_n", n_a, 0);
    chk("clrdrop_level", lv_a, 8);

    // Reset in the middle of traffic
    rst = 1'b1;
    cyc(1'b1, 8'd55, 1'b1, 1'b0);
    chk("midrst_level", lv_a, 0);
    chk("midrst_valid", ov_a, 0);
    chk("midrst_ovf", ovf_a, 0);
    rst = 1'b0;
    cyc(1'b1, 8'd42, 1'b0, 1'b0);
    chk("postrst_data", od_a, 42);
    chk("postrst_level", lv_a, 1);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
